// File: rtl/pipeline_stage_register.sv
// -----------------------------------------------------------------------------
// pipeline_stage_register
//
// Generic inter-stage pipeline register with a valid/ready handshake on both
// sides. A head register drives the outputs. A skid register absorbs the one
// extra entry that can arrive while downstream stalls. Because of the skid,
// ready_out depends only on registered state. Every entry carries a HALT
// sideband bit. When HOLD_ON_HALT is set, the stage stops accepting input once
// a halted entry has been taken.
//
// Parameters:
//   DATA_WIDTH   payload width
//   RESET_DATA   data_out value after reset
//   FLUSH_DATA   data_out value after flush
//   HOLD_ON_HALT 1: block input after a halted entry is accepted
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   flush      synchronous flush, discards every held entry
//   valid_in   upstream entry valid
//   ready_out  stage can accept an entry this cycle (registered-only path)
//   data_in    upstream payload
//   halt_in    HALT flag accompanying data_in
//   valid_out  head entry valid
//   ready_in   downstream accepts the head this cycle
//   data_out   head payload
//   halt_out   HALT flag of the head entry
//   occupancy  number of held entries (0..2)
//   halted     a halted entry was accepted since the last reset or flush
// -----------------------------------------------------------------------------
module pipeline_stage_register #(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA   = {32'hBFC00000, 32'h0},
    parameter logic [DATA_WIDTH-1:0] FLUSH_DATA   = '0,
    parameter bit                    HOLD_ON_HALT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  halt_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  halt_out,
    output logic [1:0]            occupancy,
    output logic                  halted
);

    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_halt;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_halt;
    logic                  halted_q;

    logic accept;
    logic deliver;

    // NOTE: continuous assigns cannot infer latches. Every combinational term
    // below is fully defined, so no always_comb default is needed.
    // ready_out comes only from registers. A free skid slot guarantees that
    // any accepted entry has somewhere to go.
    assign ready_out = !skid_valid && !(HOLD_ON_HALT && halted_q);
    assign accept    = valid_in && ready_out;
    assign deliver   = head_valid && ready_in;

    assign valid_out = head_valid;
    assign data_out  = head_data;
    assign halt_out  = head_halt;
    assign halted    = halted_q;
    assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

    // NOTE: all state here uses non-blocking assignments. Every register then
    // samples the pre-edge values, which keeps the head/skid shuffle
    // order-independent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_valid <= 1'b0;
            head_data  <= RESET_DATA;
            head_halt  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_halt  <= 1'b0;
            halted_q   <= 1'b0;
        end else if (flush) begin
            // Input offered in a flush cycle is dropped on purpose.
            head_valid <= 1'b0;
            head_data  <= FLUSH_DATA;
            head_halt  <= 1'b0;
            skid_valid <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            if (accept && halt_in) begin
                halted_q <= 1'b1;
            end

            if (!head_valid) begin
                // An empty head implies an empty skid, so input goes straight in.
                if (accept) begin
                    head_valid <= 1'b1;
                    head_data  <= data_in;
                    head_halt  <= halt_in;
                end
            end else if (skid_valid) begin
                // Full stage: ready_out is low, so the only event is a drain.
                if (deliver) begin
                    head_data  <= skid_data;
                    head_halt  <= skid_halt;
                    skid_valid <= 1'b0;
                end
            end else if (deliver) begin
                if (accept) begin
                    head_data <= data_in;
                    head_halt <= halt_in;
                end else begin
                    // The head empties but keeps its last payload visible.
                    head_valid <= 1'b0;
                end
            end else if (accept) begin
                // Downstream is stalled, so the younger entry parks in the skid.
                skid_valid <= 1'b1;
                skid_data  <= data_in;
                skid_halt  <= halt_in;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_stage_register.
// The stimulus process drives inputs just after each rising edge. A model
// process updates a reference queue on each rising edge. A monitor process
// compares the DUT against the model on each falling edge.
// A second instance with HOLD_ON_HALT=0 and ready_in tied high shares the
// stimulus. It must behave as a pure one-cycle register.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_register;

    localparam int          DW   = 64;
    localparam logic [63:0] RST_D = {32'hBFC00000, 32'h0};
    localparam logic [63:0] FLS_D = 64'h0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          halt_in = 1'b0;
    logic          ready_in = 1'b0;

    logic          ready_out, valid_out, halt_out, halted;
    logic [DW-1:0] data_out;
    logic [1:0]    occupancy;

    logic          nh_ready_out, nh_valid_out, nh_halt_out, nh_halted;
    logic [DW-1:0] nh_data_out;
    logic [1:0]    nh_occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          halt;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        sb[$];
    int            mocc = 0;
    bit            mhalted = 1'b0;
    logic [DW-1:0] idle_data = RST_D;
    bit            nh_exp_v = 1'b0;
    logic [DW-1:0] nh_exp_d = RST_D;
    bit            done = 1'b0;

    pipeline_stage_register #(
        .DATA_WIDTH(DW), .RESET_DATA(RST_D), .FLUSH_DATA(FLS_D), .HOLD_ON_HALT(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in), .halt_in(halt_in),
        .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out), .halt_out(halt_out),
        .occupancy(occupancy), .halted(halted)
    );

    pipeline_stage_register #(
        .DATA_WIDTH(DW), .RESET_DATA(RST_D), .FLUSH_DATA(FLS_D), .HOLD_ON_HALT(1'b0)
    ) u_nohold (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(valid_in), .ready_out(nh_ready_out), .data_in(data_in), .halt_in(halt_in),
        .valid_out(nh_valid_out), .ready_in(1'b1), .data_out(nh_data_out), .halt_out(nh_halt_out),
        .occupancy(nh_occupancy), .halted(nh_halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances with the DUT on each rising edge.
    always @(posedge clk) begin
        bit acc, dlv;
        if (!reset) begin
            sb.delete();
            mocc      = 0;
            mhalted   = 1'b0;
            idle_data = RST_D;
            nh_exp_v  = 1'b0;
            nh_exp_d  = RST_D;
        end else if (flush) begin
            sb.delete();
            mocc      = 0;
            mhalted   = 1'b0;
            idle_data = FLS_D;
            nh_exp_v  = 1'b0;
            nh_exp_d  = FLS_D;
        end else begin
            acc = valid_in && (mocc < 2) && !mhalted;
            dlv = (mocc > 0) && ready_in;
            if (acc) begin
                sb.push_back({halt_in, data_in});
                if (halt_in) mhalted = 1'b1;
            end
            mocc = mocc + int'(acc) - int'(dlv);
            nh_exp_v = valid_in;
            if (valid_in) nh_exp_d = data_in;
        end
    end

    // Monitor: compares away from the active edge and pops the scoreboard on
    // each delivery.
    always @(negedge clk) begin
        entry_t e;
        check("ready_out", {63'b0, ready_out}, {63'b0, (mocc < 2) && !mhalted});
        check("occupancy", {62'b0, occupancy}, 64'(mocc));
        check("valid_out", {63'b0, valid_out}, {63'b0, mocc > 0});
        check("halted", {63'b0, halted}, {63'b0, mhalted});
        check("skid_invariant", {63'b0, !(u_dut.skid_valid && !u_dut.head_valid)}, 64'd1);
        if (valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_output", data_out, 64'hDEAD_0000_0000_DEAD ^ data_out ^ 64'h1);
            end else begin
                e = sb[0];
                check("data_out", data_out, e.data);
                check("halt_out", {63'b0, halt_out}, {63'b0, e.halt});
                if (ready_in && reset && !flush) begin
                    idle_data = e.data;
                    void'(sb.pop_front());
                end
            end
        end else begin
            check("idle_data_out", data_out, idle_data);
        end
        check("nh_ready_out", {63'b0, nh_ready_out}, 64'd1);
        check("nh_valid_out", {63'b0, nh_valid_out}, {63'b0, nh_exp_v});
        check("nh_data_out", nh_data_out, nh_exp_d);
    end

    task automatic drive(input bit v, input logic [63:0] d, input bit h,
                         input bit rdy, input bit fl, input bit rs);
        valid_in = v;
        data_in  = d;
        halt_in  = h;
        ready_in = rdy;
        flush    = fl;
        reset    = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles, then released.
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", data_out, 64'hBFC00000_00000000);
        check("reset_valid", {63'b0, valid_out}, 64'd0);
        reset = 1'b1;
        #1;
        check("reset_ready", {63'b0, ready_out}, 64'd1);

        // Stream 1,2,3 with ready_in high.
        drive(1, 64'd1, 0, 1, 0, 1);
        check("stream_first", data_out, 64'd1);
        check("stream_occ", {62'b0, occupancy}, 64'd1);
        drive(1, 64'd2, 0, 1, 0, 1);
        drive(1, 64'd3, 0, 1, 0, 1);
        drive(0, 64'd0, 0, 1, 0, 1);

        // Backpressure into the skid, then drain.
        drive(1, 64'h10, 0, 0, 0, 1);
        drive(1, 64'h20, 0, 0, 0, 1);
        check("skid_occ", {62'b0, occupancy}, 64'd2);
        check("skid_ready", {63'b0, ready_out}, 64'd0);
        drive(1, 64'h30, 0, 0, 0, 1);
        drive(1, 64'h30, 0, 1, 0, 1);
        check("drain_head", data_out, 64'h20);
        check("drain_ready", {63'b0, ready_out}, 64'd1);
        drive(1, 64'h30, 0, 1, 0, 1);
        check("c_accepted", data_out, 64'h30);
        drive(0, 64'd0, 0, 1, 0, 1);

        // Flush with a full stage and a competing input.
        drive(1, 64'hA1, 0, 0, 0, 1);
        drive(1, 64'hA2, 0, 0, 0, 1);
        drive(1, 64'h55, 0, 0, 1, 1);
        check("flush_valid", {63'b0, valid_out}, 64'd0);
        check("flush_data", data_out, 64'h0);
        check("flush_ready", {63'b0, ready_out}, 64'd1);
        drive(0, 64'd0, 0, 1, 0, 1);

        // Halt blocks further input until a flush.
        drive(1, 64'h7, 1, 0, 0, 1);
        check("halt_set", {63'b0, halted}, 64'd1);
        check("halt_out", {63'b0, halt_out}, 64'd1);
        check("halt_ready", {63'b0, ready_out}, 64'd0);
        drive(1, 64'h8, 0, 0, 0, 1);
        drive(0, 64'h0, 0, 1, 0, 1);
        drive(1, 64'h9, 0, 1, 0, 1);
        drive(0, 64'h0, 0, 0, 1, 1);
        check("halt_cleared", {63'b0, halted}, 64'd0);
        check("halt_ready_back", {63'b0, ready_out}, 64'd1);
        drive(1, 64'hB, 0, 1, 0, 1);
        drive(0, 64'h0, 0, 1, 0, 1);

        // Reset while full, alone and then together with flush.
        drive(1, 64'hC1, 0, 0, 0, 1);
        drive(1, 64'hC2, 0, 0, 0, 1);
        drive(0, 64'h0, 0, 0, 0, 0);
        check("rst_mid_data", data_out, RST_D);
        drive(1, 64'hD1, 0, 0, 0, 1);
        drive(1, 64'hD2, 0, 0, 0, 1);
        drive(1, 64'hD3, 0, 0, 1, 0);
        check("rst_flush_data", data_out, RST_D);
        drive(0, 64'h0, 0, 1, 0, 1);

        // Randomised soak.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 999) != 0);
        end
        repeat (4) drive(0, 64'h0, 0, 1, 0, 1);
        check("final_drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_register.md
Name: pipeline_stage_register

Overview:
- Generic, parametrised inter-stage pipeline register. It replaces the fixed-width, enable/clear-style stage registers between fetch/decode/execute/memory/writeback.
- Adds a valid/ready handshake on both sides and a 2-entry skid buffer, so upstream ready is registered and no combinational ready path crosses the stage.
- Adds a synchronous flush and a sideband HALT bit that travels with each entry.
- Optionally blocks further input once a halted entry has been accepted.

Parameters:
DATA_WIDTH, 64, payload width (e.g. {pc_plus_four, instruction}).
RESET_DATA, {32'hBFC00000, 32'h0}, value of data_out after reset.
FLUSH_DATA, 64'h0, value of data_out after flush.
HOLD_ON_HALT, 1, 1: stop accepting input after an entry with halt set is accepted; 0: halt is pure sideband.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-low reset; reset==0 sampled at posedge resets the block.
flush  input  1  synchronous flush, discards all held entries.
valid_in  input  1  upstream entry valid.
ready_out  output  1  stage can accept an entry this cycle.
data_in  input  DATA_WIDTH  upstream payload.
halt_in  input  1  HALT flag accompanying data_in.
valid_out  output  1  head entry valid.
ready_in  input  1  downstream accepts head this cycle.
data_out  output  DATA_WIDTH  head payload.
halt_out  output  1  HALT flag of head entry.
occupancy  output  2  number of held entries (0..2).
halted  output  1  a halted entry has been accepted since the last reset or flush.

Behaviour:
- Storage: a head register (data/halt/valid), which drives the outputs directly, and a skid register (data/halt/valid). Order is FIFO; the skid entry is always younger than the head.
- Transfer rules:
  - accept = valid_in & ready_out
  - deliver = valid_out & ready_in
- ready_out = !skid_valid & !(HOLD_ON_HALT & halted). This is a function of registers only; there is no path from ready_in or valid_in.
- Per-cycle update (reset low: reset; else flush: flush; else):
  - head empty, accept: the input loads into the head.
  - head full, deliver, skid empty, accept: the input loads into the head.
  - head full, deliver, skid empty, no accept: the head empties.
  - head full, no deliver, accept: the input loads into the skid.
  - head full, skid full, deliver: the skid moves to the head and the skid empties. No accept is possible in this state.
  - Otherwise the block holds.
- An empty head keeps its last data_out value; data_out is only meaningful while valid_out=1.
- halted sets on any accept with halt_in=1 and stays set until reset or flush.
- Reset (reset==0 at posedge), highest priority:
  - data_out=RESET_DATA, halt_out=0, valid_out=0
  - skid cleared, occupancy=0, halted=0
  - ready_out=1 from the first cycle after reset deasserts
  - Reset mid-transfer drops all entries silently.
- Flush (reset==1, flush==1):
  - Both entries are invalidated, data_out=FLUSH_DATA, halt_out=0, halted=0, occupancy=0.
  - Any input offered in the same cycle is dropped, even if ready_out was 1.
  - ready_out=1 on the next cycle.
- Latency: 1 cycle from accept to valid_out when the stage is empty. Throughput is 1 entry/cycle when ready_in stays high.
- occupancy = head_valid + skid_valid and is always consistent with the valid bits.
- Invariant: skid_valid implies head_valid. The bench must assert this.
- Held data must not change while valid_out=1 and ready_in=0.

Test Plan:
- Reset then stream: hold reset=0 for 2 cycles, then release. Required: data_out=64'hBFC00000_00000000, valid_out=0, ready_out=1. Next, drive valid_in=1 with data 1,2,3 on consecutive cycles, ready_in=1. Required: valid_out=1 carrying 1,2,3 on cycles +1,+2,+3; occupancy stays 1.
- Backpressure/skid: with ready_in=0, offer A=0x10 and then B=0x20. Required: occupancy=2 and ready_out=0 after B; C=0x30 offered next is not accepted. Then raise ready_in=1. Required: outputs are 0x10 then 0x20, ready_out=1 the cycle after 0x10 is delivered, and C is accepted then.
- Flush with full stage: stage holding 2 entries, flush=1 with valid_in=1 and data 0x55. Required next cycle: valid_out=0, data_out=0, occupancy=0, ready_out=1; 0x55 never appears at the output.
- Halt (HOLD_ON_HALT=1): accept data 0x7 with halt_in=1. Required: halted=1, ready_out=0 thereafter, and head shows 0x7 with halt_out=1 until delivered. A subsequent flush clears halted and restores ready_out=1. With HOLD_ON_HALT=0, streaming continues uninterrupted.
- Reset mid-backpressure: stage full and ready_in=0, assert reset=0 for 1 cycle. Required: occupancy=0, valid_out=0, data_out=RESET_DATA, halted=0. A simultaneous flush=1 gives the same result, since reset has priority.
- Randomised ready/valid soak of 10k cycles against a reference queue model. Required: the output sequence equals the accepted sequence; no loss and no duplication; the skid invariant always holds.
